riscv_tag_trap_ctrl: RTL and testbench

RISCV_TAG_TRAP_CTRL -- requirements
Module: riscv_tag_trap_ctrl

---
 rtl/riscv_tag_trap_ctrl.sv | 126 ++++++++++++
 tb/tb_riscv_tag_trap_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_tag_trap_ctrl.sv
// DIFT tag-violation trap controller: squashes the offending EX instruction,
// captures its PC and cause, and raises a trap request until the controller acks.
module riscv_tag_trap_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 ex_valid_i,
    input  logic                 exception_i_tag,
    input  logic                 check_s1_i_tag,
    input  logic                 check_s2_i_tag,
    input  logic                 check_d_i_tag,
    input  logic                 operand_a_i_tag,
    input  logic                 operand_b_i_tag,
    input  logic                 result_i_tag,
    input  logic [31:0]          pc_ex_i,
    input  logic                 trap_ack_i,
    input  logic                 clear_i,
    output logic                 trap_req_o,
    output logic [31:0]          trap_pc_o,
    output logic [2:0]           trap_cause_o,
    output logic                 stall_o,
    output logic                 squash_o,
    output logic                 fatal_o,
    output logic                 lost_o,
    output logic [CNT_WIDTH-1:0] trap_cnt_o,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_FATAL} state_t;

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t               r_state;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_trap_req;
    logic                 r_stall;
    logic                 r_fatal;
    logic                 r_lost;
    logic [31:0]          r_pc;
    logic [2:0]           r_cause;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_hit;
    logic                 w_hit_idle;
    logic                 w_timeout;
    logic [2:0]           w_cause;

    assign w_hit      = enable_i & ex_valid_i & exception_i_tag;
    assign w_hit_idle = w_hit & (r_state == S_IDLE);
    assign w_cause    = {check_d_i_tag  & result_i_tag,
                         check_s2_i_tag & operand_b_i_tag,
                         check_s1_i_tag & operand_a_i_tag};
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_to_cnt == TO_LAST);

    // Handshake: trap_req_o holds high with a stable pc/cause until the first
    // edge that samples trap_ack_i=1; that edge completes the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_to_cnt   <= '0;
            r_trap_req <= 1'b0;
            r_stall    <= 1'b0;
            r_fatal    <= 1'b0;
            r_lost     <= 1'b0;
            r_pc       <= '0;
            r_cause    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_state    <= S_REQ;
                        r_trap_req <= 1'b1;
                        r_stall    <= 1'b1;
                        r_to_cnt   <= '0;
                        r_pc       <= pc_ex_i;
                        r_cause    <= w_cause;
                    end
                end
                S_REQ: begin
                    if (trap_ack_i) begin
                        r_state    <= S_DRAIN;
                        r_trap_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_state    <= S_FATAL;
                        r_trap_req <= 1'b0;
                        r_fatal    <= 1'b1;
                    end else begin
                        r_to_cnt   <= r_to_cnt + TO_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
                default: r_state <= S_FATAL;
            endcase

            // Clear wins over a busy drop; an accepted hit in the same cycle still counts.
            if (clear_i) begin
                r_lost <= 1'b0;
                r_cnt  <= w_hit_idle ? CNT_WIDTH'(1) : '0;
            end else begin
                if (w_hit && (r_state != S_IDLE))
                    r_lost <= 1'b1;
                if (w_hit_idle && !(&r_cnt))
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign squash_o     = w_hit_idle & ~rst;
    assign trap_req_o   = r_trap_req;
    assign trap_pc_o    = r_pc;
    assign trap_cause_o = r_cause;
    assign stall_o      = r_stall;
    assign fatal_o      = r_fatal;
    assign lost_o       = r_lost;
    assign trap_cnt_o   = r_cnt;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_riscv_tag_trap_ctrl.sv
// Bench for riscv_tag_trap_ctrl: a cycle model predicts every registered output
// into a queue; directed scenarios are followed by a random phase.
module tb_riscv_tag_trap_ctrl;

    localparam int TO = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i, ex_valid_i, exception_i_tag;
    logic          check_s1_i_tag, check_s2_i_tag, check_d_i_tag;
    logic          operand_a_i_tag, operand_b_i_tag, result_i_tag;
    logic [31:0]   pc_ex_i;
    logic          trap_ack_i, clear_i;
    logic          trap_req_o, stall_o, squash_o, fatal_o, lost_o;
    logic [31:0]   trap_pc_o;
    logic [2:0]    trap_cause_o;
    logic [CW-1:0] trap_cnt_o;
    logic [1:0]    o_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [40:0] exp_q[$];

    // reference model
    int          m_state;
    int          m_req;
    int          m_cnt;
    logic        m_lost;
    logic [31:0] m_pc;
    logic [2:0]  m_cause;

    riscv_tag_trap_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .ex_valid_i(ex_valid_i),
        .exception_i_tag(exception_i_tag), .check_s1_i_tag(check_s1_i_tag),
        .check_s2_i_tag(check_s2_i_tag), .check_d_i_tag(check_d_i_tag),
        .operand_a_i_tag(operand_a_i_tag), .operand_b_i_tag(operand_b_i_tag),
        .result_i_tag(result_i_tag), .pc_ex_i(pc_ex_i), .trap_ack_i(trap_ack_i),
        .clear_i(clear_i), .trap_req_o(trap_req_o), .trap_pc_o(trap_pc_o),
        .trap_cause_o(trap_cause_o), .stall_o(stall_o), .squash_o(squash_o),
        .fatal_o(fatal_o), .lost_o(lost_o), .trap_cnt_o(trap_cnt_o),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; ex_valid_i = 1'b0; exception_i_tag = 1'b0;
        check_s1_i_tag = 1'b0; check_s2_i_tag = 1'b0; check_d_i_tag = 1'b0;
        operand_a_i_tag = 1'b0; operand_b_i_tag = 1'b0; result_i_tag = 1'b0;
        pc_ex_i = '0; trap_ack_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic set_hit(input logic [31:0] pc, input logic [2:0] chk, input logic [2:0] tags);
        ex_valid_i = 1'b1; exception_i_tag = 1'b1; pc_ex_i = pc;
        {check_d_i_tag, check_s2_i_tag, check_s1_i_tag} = chk;
        {result_i_tag, operand_b_i_tag, operand_a_i_tag} = tags;
    endtask

    // Apply the current inputs for one cycle: check squash combinationally,
    // push the predicted post-edge outputs, then pop and compare after the edge.
    task automatic step();
        logic        hit;
        logic        hit_idle;
        logic [2:0]  cause;
        logic [40:0] e;
        hit      = enable_i & ex_valid_i & exception_i_tag;
        hit_idle = hit && (m_state == 0);
        cause    = {check_d_i_tag & result_i_tag, check_s2_i_tag & operand_b_i_tag,
                    check_s1_i_tag & operand_a_i_tag};
        #1;
        check("squash", {31'd0, squash_o}, {31'd0, (!rst && hit_idle)});
        if (rst) begin
            m_state = 0; m_req = 0; m_cnt = 0; m_lost = 1'b0; m_pc = '0; m_cause = '0;
        end else begin
            if (clear_i) begin
                m_lost = 1'b0;
                m_cnt  = hit_idle ? 1 : 0;
            end else begin
                if (hit && m_state != 0) m_lost = 1'b1;
                if (hit_idle && m_cnt < (1 << CW) - 1) m_cnt++;
            end
            case (m_state)
                0: if (hit) begin m_state = 1; m_req = 1; m_pc = pc_ex_i; m_cause = cause; end
                1: begin
                    if (trap_ack_i) m_state = 2;
                    else if (m_req == TO) m_state = 3;
                    else m_req++;
                end
                2: m_state = 0;
                default: m_state = 3;
            endcase
        end
        exp_q.push_back({m_state == 1, m_state != 0, m_state == 3, m_lost, 2'(m_cnt), m_cause, m_pc});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("trap_req", {31'd0, trap_req_o}, {31'd0, e[40]});
        check("stall",    {31'd0, stall_o},    {31'd0, e[39]});
        check("fatal",    {31'd0, fatal_o},    {31'd0, e[38]});
        check("lost",     {31'd0, lost_o},     {31'd0, e[37]});
        check("cnt",      {30'd0, trap_cnt_o}, {30'd0, e[36:35]});
        check("cause",    {29'd0, trap_cause_o}, {29'd0, e[34:32]});
        check("pc",       trap_pc_o, e[31:0]);
    endtask

    initial begin
        m_state = 0; m_req = 0; m_cnt = 0; m_lost = 1'b0; m_pc = '0; m_cause = '0;
        enable_i = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        // reset with a pending hit: no squash, everything zero
        idle_inputs(); set_hit(32'h0000_0BAD, 3'b111, 3'b111); rst = 1'b1; step();
        idle_inputs(); rst = 1'b1; step();
        check("rst_pc", trap_pc_o, 32'h0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);

        // basic trap
        idle_inputs(); set_hit(32'h0000_1A40, 3'b001, 3'b001); step();
        check("basic_req", {31'd0, trap_req_o}, 32'd1);
        check("basic_pc", trap_pc_o, 32'h0000_1A40);
        check("basic_cause", {29'd0, trap_cause_o}, 32'd1);
        check("basic_cnt", {30'd0, trap_cnt_o}, 32'd1);
        idle_inputs(); step(); step();
        trap_ack_i = 1'b1; step();
        check("basic_req_drop", {31'd0, trap_req_o}, 32'd0);
        check("basic_drain_stall", {31'd0, stall_o}, 32'd1);
        idle_inputs(); step();
        check("basic_stall_drop", {31'd0, stall_o}, 32'd0);

        // busy drop
        idle_inputs(); set_hit(32'h0000_1A40, 3'b001, 3'b001); step();
        idle_inputs(); set_hit(32'h0000_2000, 3'b110, 3'b110); step();
        check("busy_lost", {31'd0, lost_o}, 32'd1);
        check("busy_pc", trap_pc_o, 32'h0000_1A40);
        check("busy_cnt", {30'd0, trap_cnt_o}, 32'd2);
        idle_inputs(); trap_ack_i = 1'b1; step();
        idle_inputs(); step();

        // ack coinciding with the timeout on the 4th REQ cycle
        idle_inputs(); set_hit(32'h0000_3000, 3'b010, 3'b010); step();
        idle_inputs(); step(); step(); step();
        trap_ack_i = 1'b1; step();
        check("collide_fatal", {31'd0, fatal_o}, 32'd0);
        check("collide_cause", {29'd0, trap_cause_o}, 32'd2);
        idle_inputs(); step();

        // saturation at 3 then clear with a concurrent IDLE hit
        idle_inputs(); set_hit(32'h0000_4000, 3'b100, 3'b100); step();
        check("sat_cnt", {30'd0, trap_cnt_o}, 32'd3);
        idle_inputs(); trap_ack_i = 1'b1; step();
        idle_inputs(); step();
        set_hit(32'h0000_5000, 3'b111, 3'b101); clear_i = 1'b1; step();
        check("clear_cnt", {30'd0, trap_cnt_o}, 32'd1);
        check("clear_lost", {31'd0, lost_o}, 32'd0);
        check("clear_cause", {29'd0, trap_cause_o}, 32'd5);

        // timeout into FATAL, sticky through ack and clear
        idle_inputs(); step(); step(); step();
        check("to_req_last", {31'd0, trap_req_o}, 32'd1);
        step();
        check("to_fatal", {31'd0, fatal_o}, 32'd1);
        check("to_req_off", {31'd0, trap_req_o}, 32'd0);
        trap_ack_i = 1'b1; clear_i = 1'b1; step();
        idle_inputs(); set_hit(32'h0000_6000, 3'b001, 3'b001); step();
        check("to_sticky", {31'd0, fatal_o}, 32'd1);
        check("to_pc_held", trap_pc_o, 32'h0000_5000);

        // disabled policy ignores violations
        idle_inputs(); rst = 1'b1; step();
        idle_inputs(); enable_i = 1'b0; set_hit(32'h0000_7000, 3'b111, 3'b111); step(); step();
        check("dis_req", {31'd0, trap_req_o}, 32'd0);
        check("dis_cnt", {30'd0, trap_cnt_o}, 32'd0);

        // enable dropped mid-trap, then reset mid-REQ
        enable_i = 1'b1; step();
        enable_i = 1'b0; idle_inputs(); step();
        check("dis_mid_req", {31'd0, trap_req_o}, 32'd1);
        enable_i = 1'b1; rst = 1'b1; step();
        check("rst_mid_req", {31'd0, trap_req_o}, 32'd0);
        check("rst_mid_pc", trap_pc_o, 32'h0);

        // random phase
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            rst             = ($urandom_range(0, 29) == 0);
            enable_i        = ($urandom_range(0, 7) != 0);
            ex_valid_i      = $urandom_range(0, 1);
            exception_i_tag = ($urandom_range(0, 2) == 0);
            {check_d_i_tag, check_s2_i_tag, check_s1_i_tag}   = 3'($urandom_range(0, 7));
            {result_i_tag, operand_b_i_tag, operand_a_i_tag} = 3'($urandom_range(0, 7));
            pc_ex_i    = $urandom;
            trap_ack_i = ($urandom_range(0, 3) == 0);
            clear_i    = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
